// File: rtl/cic_dec_pkg.sv
// Shared constants and helpers for the CIC decimation filter.
//   cic_acc_w()   : accumulator width IN_W + N*R_LOG2 (bit growth R^N)
//   CIC_DEF_*     : default configuration (2-bit input, 16-bit output,
//                   4 stages, decimation ratio 64)
package cic_dec_pkg;

    localparam int unsigned CIC_DEF_IN_W   = 2;
    localparam int unsigned CIC_DEF_OUT_W  = 16;
    localparam int unsigned CIC_DEF_N      = 4;
    localparam int unsigned CIC_DEF_R_LOG2 = 6;

    function automatic int unsigned cic_acc_w(input int unsigned in_w,
                                              input int unsigned n,
                                              input int unsigned r_log2);
        return in_w + n * r_log2;
    endfunction

endpackage

// File: rtl/cic_decimator_if.sv
// Sample-stream bundle of the CIC decimator.
//   clk_enable : input-rate strobe, one sample consumed per high cycle
//   filter_in  : signed modulator sample (IN_W bits)
//   filter_out : signed decimated sample (OUT_W bits), held between updates
//   ce_out     : one-cycle pulse marking a new filter_out
// master = upstream side (modulator/driver), slave = the decimator.
interface cic_decimator_if #(
    parameter int unsigned IN_W  = 2,
    parameter int unsigned OUT_W = 16
);
    logic                    clk_enable;
    logic signed [IN_W-1:0]  filter_in;
    logic signed [OUT_W-1:0] filter_out;
    logic                    ce_out;

    modport master (
        output clk_enable,
        output filter_in,
        input  filter_out,
        input  ce_out
    );

    modport slave (
        input  clk_enable,
        input  filter_in,
        output filter_out,
        output ce_out
    );
endinterface

// File: rtl/cic_dec_comb.sv
// Single CIC comb stage: y <= x - x_delayed, with a one-sample delay,
// both registers advancing only on the decimated-rate enable.
//   clk, reset : clock, asynchronous active-high reset
//   en         : decimation strobe
//   comb_in    : stage input (W bits, signed, wraps)
//   comb_out   : registered stage output
module cic_dec_comb #(
    parameter int unsigned W = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic signed [W-1:0] comb_in,
    output logic signed [W-1:0] comb_out
);
    logic signed [W-1:0] c_q, c_d;
    logic signed [W-1:0] dly_q, dly_d;

    always_comb begin
        c_d   = c_q;
        dly_d = dly_q;
        if (en) begin
            c_d   = comb_in - dly_q;
            dly_d = comb_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_q   <= '0;
            dly_q <= '0;
        end else begin
            c_q   <= c_d;
            dly_q <= dly_d;
        end
    end

    assign comb_out = c_q;
endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator: sigma-delta bitstream in, 16-bit PCM out at 1/R rate.
//   clk   : single clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : cic_decimator_if.slave (clk_enable, filter_in, filter_out, ce_out)
// Optional build macro CIC_DECIMATOR_ROUND_EN: round-half-up the final
// scaling instead of truncating; latency is identical in both builds.
module cic_decimator
    import cic_dec_pkg::*;
#(
    parameter int unsigned IN_W   = CIC_DEF_IN_W,
    parameter int unsigned OUT_W  = CIC_DEF_OUT_W,
    parameter int unsigned N      = CIC_DEF_N,
    parameter int unsigned R_LOG2 = CIC_DEF_R_LOG2
) (
    input  logic            clk,
    input  logic            reset,
    cic_decimator_if.slave  bus
);
    localparam int unsigned ACC_W = cic_acc_w(IN_W, N, R_LOG2);
    localparam int unsigned SHIFT = ACC_W - OUT_W;

    typedef logic signed [ACC_W-1:0] acc_t;

    acc_t                    integ_q [N];
    acc_t                    integ_d [N];
    acc_t                    in_ext;
    logic [R_LOG2-1:0]       cnt_q, cnt_d;
    logic                    dec;
    acc_t                    comb_x [N+1];
    logic signed [OUT_W-1:0] scaled;
    logic signed [OUT_W-1:0] filter_out_q, filter_out_d;
    logic                    ce_out_q, ce_out_d;

    assign in_ext = {{(ACC_W - IN_W){bus.filter_in[IN_W-1]}}, bus.filter_in};

    // Integrators feed from the previous stage's register, so the chain is
    // pipelined one sample per stage; modular wrap is cancelled by the combs.
    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            integ_d[k] = integ_q[k];
        end
        if (bus.clk_enable) begin
            integ_d[0] = integ_q[0] + in_ext;
            for (int unsigned k = 1; k < N; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
        end
    end

    assign dec   = bus.clk_enable && (cnt_q == '1);
    assign cnt_d = bus.clk_enable ? cnt_q + R_LOG2'(1) : cnt_q;

    assign comb_x[0] = integ_q[N-1];

    for (genvar k = 0; k < N; k++) begin : g_comb
        cic_dec_comb #(
            .W (ACC_W)
        ) u_comb (
            .clk      (clk),
            .reset    (reset),
            .en       (dec),
            .comb_in  (comb_x[k]),
            .comb_out (comb_x[k+1])
        );
    end

`ifdef CIC_DECIMATOR_ROUND_EN
    // One guard bit keeps the rounding offset from wrapping near full scale.
    localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) << (SHIFT - 1);
    logic signed [ACC_W:0] rnd_sum, rnd_shr;

    always_comb begin
        rnd_sum = {comb_x[N][ACC_W-1], comb_x[N]} + HALF;
        rnd_shr = rnd_sum >>> SHIFT;
    end

    assign scaled = OUT_W'(rnd_shr);
`else
    acc_t trunc_shr;

    assign trunc_shr = comb_x[N] >>> SHIFT;
    assign scaled    = OUT_W'(trunc_shr);
`endif

    always_comb begin
        filter_out_d = dec ? scaled : filter_out_q;
        ce_out_d     = dec;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < N; k++) begin
                integ_q[k] <= '0;
            end
            cnt_q        <= '0;
            filter_out_q <= '0;
            ce_out_q     <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                integ_q[k] <= integ_d[k];
            end
            cnt_q        <= cnt_d;
            filter_out_q <= filter_out_d;
            ce_out_q     <= ce_out_d;
        end
    end

    assign bus.filter_out = filter_out_q;
    assign bus.ce_out     = ce_out_q;
endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator: each completed input frame of R enabled
// samples pushes the expected next output; the monitor pops on every ce_out.
module tb_cic_decimator;
    import cic_dec_pkg::*;

    localparam int R       = 64;
    localparam int FS_POS  = 16384;
    localparam int FS_NEG  = -16384;

    typedef struct {
        bit chk;   // value is checked (past filter transient)
        int val;   // expected filter_out
        int gap;   // expected clocks since previous ce_out, 0 = skip
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    cic_decimator_if #(.IN_W(CIC_DEF_IN_W), .OUT_W(CIC_DEF_OUT_W)) bus ();

    cic_decimator #(
        .IN_W   (CIC_DEF_IN_W),
        .OUT_W  (CIC_DEF_OUT_W),
        .N      (CIC_DEF_N),
        .R_LOG2 (CIC_DEF_R_LOG2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each ce_out, checks value, frame length
    // in enabled samples, pulse spacing, and that filter_out holds in between.
    initial begin : monitor
        int   en_cnt;
        int   cyc_cnt;
        bit   first_after;
        bit   hold_known;
        int   hold_val;
        exp_t e;
        en_cnt = 0; cyc_cnt = 0; first_after = 1; hold_known = 1; hold_val = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                en_cnt = 0; cyc_cnt = 0; first_after = 1;
                hold_known = 1; hold_val = 0;
            end else begin
                cyc_cnt++;
                if (bus.ce_out) begin
                    if (sb.size() == 0) begin
                        check_val("ce_spurious", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check_val("en_per_frame", en_cnt, R);
                        if (e.gap != 0 && !first_after)
                            check_val("ce_period", cyc_cnt, e.gap);
                        if (e.chk) begin
                            check_val("out_value", bus.filter_out, e.val);
                            hold_known = 1;
                            hold_val   = e.val;
                        end else begin
                            hold_known = 0;
                        end
                    end
                    en_cnt = 0; cyc_cnt = 0; first_after = 0;
                end else if (hold_known) begin
                    check_val("out_hold", bus.filter_out, hold_val);
                end
                if (bus.clk_enable) en_cnt++;
            end
        end
    end

    function automatic logic signed [1:0] sample(input int mode, input bit alt);
        case (mode)
            1:       return 2'sb01;
            2:       return 2'sb11;
            3:       return alt ? 2'sb11 : 2'sb01;
            default: return 2'sb00;
        endcase
    endfunction

    function automatic int steady(input int mode);
        case (mode)
            1:       return FS_POS;
            2:       return FS_NEG;
            default: return 0;
        endcase
    endfunction

    // Asserts reset between edges and checks the immediate clear.
    task automatic do_reset();
        @(posedge clk);
        #1 bus.clk_enable = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_val("rst_out_now", bus.filter_out, 0);
        check_val("rst_ce_now", bus.ce_out, 0);
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_hold", bus.filter_out, 0);
        check_val("rst_ce_hold", bus.ce_out, 0);
        sb.delete();
        reset = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        check_val("drain", sb.size(), 0);
    endtask

    // mode: 0 zero, 1 +1, 2 -1, 3 alternating; en_step: enable every n-th clock.
    task automatic run_seg(input int mode, input int nframes, input int en_step,
                           input int settle_from);
        int   ph;
        int   en_done;
        bit   alt;
        exp_t e;
        ph = 0; alt = 0;
        for (int f = 1; f <= nframes; f++) begin
            en_done = 0;
            while (en_done < R) begin
                @(posedge clk);
                #1;
                if (ph % en_step == 0) begin
                    bus.clk_enable = 1'b1;
                    bus.filter_in  = sample(mode, alt);
                    alt = ~alt;
                    en_done++;
                end else begin
                    bus.clk_enable = 1'b0;
                    bus.filter_in  = ($urandom_range(1, 0) != 0) ? 2'sb01 : 2'sb11;
                end
                ph++;
            end
            e.chk = (f >= settle_from);
            e.val = steady(mode);
            e.gap = (f > 1) ? R * en_step : 0;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 bus.clk_enable = 1'b0;
        drain();
    endtask

    initial begin : driver
        bus.clk_enable = 1'b0;
        bus.filter_in  = '0;
        #2;
        check_val("por_out", bus.filter_out, 0);
        check_val("por_ce", bus.ce_out, 0);

        do_reset();
        run_seg(1, 14, 1, 10);      // constant +1
        do_reset();
        run_seg(2, 12, 1, 10);      // constant -1
        do_reset();
        run_seg(0, 12, 1, 1);       // zero input, zero from the first pulse
        do_reset();
        run_seg(3, 12, 1, 10);      // alternating +1/-1
        do_reset();
        run_seg(1, 12, 2, 10);      // enable every second clock

        // Reset partway through a frame with the output at full scale.
        do_reset();
        run_seg(1, 11, 1, 10);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1 bus.clk_enable = 1'b1;
            bus.filter_in = 2'sb01;
        end
        do_reset();
        run_seg(1, 12, 1, 10);

        // Long +1 run: the later integrators wrap repeatedly.
        do_reset();
        run_seg(1, 60, 1, 10);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
